// File: rtl/lfsr_pkg.sv
// Shared definitions for the LFSR controller slice.
// Holds the controller state encoding, the LFSR reset/seed-substitute value,
// the feedback tap positions and the single-step function.
package lfsr_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_STEP = 2'd1,
    ST_RUN  = 2'd2
  } state_e;

  localparam logic [7:0] LFSR_INIT = 8'h01;

  localparam int unsigned TAP_A = 4;
  localparam int unsigned TAP_B = 3;
  localparam int unsigned TAP_C = 2;
  localparam int unsigned TAP_D = 0;

  // Right-shifting Fibonacci LFSR, feedback enters at bit 7.
  function automatic logic [7:0] lfsr_next(input logic [7:0] r);
    logic fb;
    fb = r[TAP_A] ^ r[TAP_B] ^ r[TAP_C] ^ r[TAP_D];
    return {fb, r[7:1]};
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Push-button conditioner: 2-flop synchronizer, counter debounce, rising-edge
// press detector.
// Ports:
//   clk     - clock
//   rst     - synchronous active-high reset
//   raw_i   - raw asynchronous bouncing button
//   press_o - one-cycle pulse per debounced 0->1 transition
module btn_debounce
  import lfsr_pkg::*;
#(
  parameter int unsigned DEB_CYCLES = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic raw_i,
  output logic press_o
);

  localparam int unsigned CW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CYCLES - 1);

  logic [1:0]    sync_q;
  logic          level_q, level_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          flip;

  // Count consecutive cycles of disagreement; any agreement clears the count.
  // The level flips on the DEB_CYCLES-th disagreeing cycle.
  always_comb begin
    level_d = level_q;
    cnt_d   = '0;
    flip    = 1'b0;
    if (sync_q[1] != level_q) begin
      if (cnt_q == CNT_LAST) begin
        flip    = 1'b1;
        level_d = sync_q[1];
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  // Press is flagged in the same cycle the level is committed to 1.
  assign press_o = flip & sync_q[1];

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q  <= '0;
      level_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync_q  <= {sync_q[0], raw_i};
      level_q <= level_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: rtl/lfsr_ctrl.sv
// Button-driven 8-bit LFSR controller: single step per press, or free-running
// auto mode toggled by a press; seed load has priority over stepping.
// Ports:
//   clk        - clock
//   rst        - synchronous active-high reset
//   bot        - raw bouncing push-button
//   auto_en    - 0: step per press, 1: press toggles free-run
//   load, seed - one-cycle seed load (seed 0 substituted by 8'h01)
//   result     - current LFSR state
//   step_pulse - high in the cycle result shows a freshly stepped value
//   running    - high while in free-run
module lfsr_ctrl
  import lfsr_pkg::*;
#(
  parameter int unsigned DEB_CYCLES  = 16,
  parameter int unsigned AUTO_PERIOD = 1000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       bot,
  input  logic       auto_en,
  input  logic       load,
  input  logic [7:0] seed,
  output logic [7:0] result,
  output logic       step_pulse,
  output logic       running
);

  localparam logic [15:0] PER_LAST = 16'(AUTO_PERIOD - 1);

  state_e      state_q, state_d;
  logic [7:0]  lfsr_q, lfsr_d;
  logic [15:0] per_q, per_d;
  logic        step_q, step_d;
  logic        do_step;
  logic        press;

  btn_debounce #(
    .DEB_CYCLES(DEB_CYCLES)
  ) u_deb (
    .clk    (clk),
    .rst    (rst),
    .raw_i  (bot),
    .press_o(press)
  );

  // A manual press steps on the IDLE->STEP edge so the new value and the
  // pulse both appear in STEP, one cycle after the press.
  always_comb begin
    state_d = state_q;
    per_d   = per_q;
    lfsr_d  = lfsr_q;
    step_d  = 1'b0;
    do_step = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (press) begin
          if (auto_en) begin
            state_d = ST_RUN;
            per_d   = '0;
          end else begin
            state_d = ST_STEP;
            do_step = 1'b1;
          end
        end
      end
      ST_STEP: state_d = ST_IDLE;
      ST_RUN: begin
        if (press || !auto_en) begin
          state_d = ST_IDLE;
        end else if (per_q == PER_LAST) begin
          per_d   = '0;
          do_step = 1'b1;
        end else begin
          per_d = per_q + 16'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Load overrides both the step and any state change in the same cycle.
    if (load) begin
      lfsr_d  = (seed == '0) ? LFSR_INIT : seed;
      state_d = state_q;
    end else if (do_step) begin
      lfsr_d = lfsr_next(lfsr_q);
      step_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      lfsr_q  <= LFSR_INIT;
      per_q   <= '0;
      step_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      lfsr_q  <= lfsr_d;
      per_q   <= per_d;
      step_q  <= step_d;
    end
  end

  assign result     = lfsr_q;
  assign step_pulse = step_q;
  assign running    = (state_q == ST_RUN);

endmodule

// File: tb/tb_lfsr_ctrl.sv
// Self-checking bench for lfsr_ctrl: table of press/load operations with
// hand-computed results, plus sequences for bounce, auto mode, load at
// terminal count, reset during run and a full 255-step cycle.
module tb_lfsr_ctrl;

  localparam int unsigned DEB = 4;
  localparam int unsigned PER = 20;

  logic       clk = 1'b0;
  logic       rst, bot, auto_en, load;
  logic [7:0] seed;
  logic [7:0] result;
  logic       step_pulse, running;

  lfsr_ctrl #(
    .DEB_CYCLES (DEB),
    .AUTO_PERIOD(PER)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .bot       (bot),
    .auto_en   (auto_en),
    .load      (load),
    .seed      (seed),
    .result    (result),
    .step_pulse(step_pulse),
    .running   (running)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  int pulse_cnt = 0;
  int pulse_cyc[$];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (step_pulse === 1'b1) begin
      pulse_cnt++;
      pulse_cyc.push_back(cyc);
    end
  end

  typedef enum {OP_PRESS, OP_LOAD} op_e;
  typedef struct {
    op_e        op;
    logic [7:0] seed;
    logic [7:0] exp_result;
    int         exp_pulses;
  } vec_t;

  vec_t vecs[8];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    repeat (n) tick();
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic press_clean();
    bot = 1'b1;
    ticks(DEB + 4);
    bot = 1'b0;
    ticks(DEB + 4);
  endtask

  task automatic do_load(input logic [7:0] s);
    load = 1'b1;
    seed = s;
    tick();
    load = 1'b0;
    seed = 8'h00;
  endtask

  task automatic wait_running(input logic want, output int at);
    int g;
    g = 0;
    while (running !== want && g < 40) begin
      tick();
      g++;
    end
    chk("wait_running", {31'd0, running}, {31'd0, want});
    at = cyc;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int p0, q0, e, x, n, g;
    logic zero_seen, early_wrap;

    vecs[0] = '{OP_PRESS, 8'h00, 8'h80, 1};
    vecs[1] = '{OP_PRESS, 8'h00, 8'h40, 1};
    vecs[2] = '{OP_PRESS, 8'h00, 8'h20, 1};
    vecs[3] = '{OP_LOAD,  8'h00, 8'h01, 0};
    vecs[4] = '{OP_LOAD,  8'hA5, 8'hA5, 0};
    vecs[5] = '{OP_PRESS, 8'h00, 8'h52, 1};
    vecs[6] = '{OP_PRESS, 8'h00, 8'hA9, 1};
    vecs[7] = '{OP_LOAD,  8'h7F, 8'h7F, 0};

    rst = 1'b1; bot = 1'b0; auto_en = 1'b0; load = 1'b0; seed = 8'h00;
    ticks(3);
    chk("rst_result", {24'd0, result}, 32'h01);
    chk("rst_running", {31'd0, running}, 32'd0);
    chk("rst_step_pulse", {31'd0, step_pulse}, 32'd0);
    rst = 1'b0;
    tick();

    // Manual presses and loads.
    for (int i = 0; i < 8; i++) begin
      p0 = pulse_cnt;
      if (vecs[i].op == OP_PRESS) press_clean();
      else begin
        do_load(vecs[i].seed);
        tick();
      end
      chk($sformatf("vec%0d_result", i), {24'd0, result}, {24'd0, vecs[i].exp_result});
      chk($sformatf("vec%0d_pulses", i), pulse_cnt - p0, vecs[i].exp_pulses);
    end

    // Bouncing press: 5 short bounces then a stable hold -> one step 7F->3F.
    p0 = pulse_cnt;
    for (int i = 0; i < 5; i++) begin
      bot = 1'b1; ticks(2);
      bot = 1'b0; ticks(2);
    end
    bot = 1'b1;
    for (int i = 0; i < 2 * DEB + 8; i++) begin
      tick();
      if (step_pulse === 1'b1) chk("bounce_pulse_result", {24'd0, result}, 32'h3F);
    end
    bot = 1'b0;
    ticks(DEB + 4);
    chk("bounce_pulses", pulse_cnt - p0, 1);
    chk("bounce_result", {24'd0, result}, 32'h3F);

    // Auto mode: three steps spaced PER apart, then a press stops it.
    do_load(8'h01);
    auto_en = 1'b1;
    p0 = pulse_cnt;
    q0 = pulse_cyc.size();
    bot = 1'b1;
    wait_running(1'b1, e);
    ticks(DEB + 4);
    bot = 1'b0;
    while (cyc < e + 3 * PER + 2) tick();
    chk("auto_pulses", pulse_cnt - p0, 3);
    if (pulse_cyc.size() >= q0 + 3) begin
      for (int k = 0; k < 3; k++)
        chk($sformatf("auto_pulse%0d_cycle", k), pulse_cyc[q0 + k], e + (k + 1) * PER);
    end
    chk("auto_result", {24'd0, result}, 32'h20);
    bot = 1'b1;
    wait_running(1'b0, x);
    ticks(DEB + 4);
    bot = 1'b0;
    ticks(2 * PER);
    chk("stop_pulses", pulse_cnt - p0, 3);
    chk("stop_result", {24'd0, result}, 32'h20);

    // Load coinciding with the auto terminal count.
    bot = 1'b1;
    wait_running(1'b1, e);
    ticks(DEB + 4);
    bot = 1'b0;
    p0 = pulse_cnt;
    while (cyc < e + PER - 1) tick();
    load = 1'b1; seed = 8'hA5;
    tick();
    load = 1'b0; seed = 8'h00;
    tick();
    chk("tc_load_result", {24'd0, result}, 32'hA5);
    chk("tc_load_pulses", pulse_cnt - p0, 0);
    chk("tc_load_running", {31'd0, running}, 32'd1);
    while (cyc < e + 2 * PER + 1) tick();
    chk("tc_next_result", {24'd0, result}, 32'h52);
    chk("tc_next_pulses", pulse_cnt - p0, 1);

    // Reset during RUN, then a normal manual press.
    rst = 1'b1;
    tick();
    chk("runrst_result", {24'd0, result}, 32'h01);
    chk("runrst_running", {31'd0, running}, 32'd0);
    chk("runrst_step_pulse", {31'd0, step_pulse}, 32'd0);
    rst = 1'b0;
    auto_en = 1'b0;
    p0 = pulse_cnt;
    press_clean();
    chk("postrst_result", {24'd0, result}, 32'h80);
    chk("postrst_pulses", pulse_cnt - p0, 1);

    // Full sequence: 255 auto steps from 01 return to 01, never 00.
    do_load(8'h01);
    auto_en = 1'b1;
    bot = 1'b1;
    wait_running(1'b1, e);
    n = 0; g = 0; zero_seen = 1'b0; early_wrap = 1'b0;
    while (n < 255 && g < 255 * PER + 100) begin
      tick();
      g++;
      if (g == DEB + 4) bot = 1'b0;
      if (step_pulse === 1'b1) n++;
      if (result == 8'h00) zero_seen = 1'b1;
      if (result == 8'h01 && n > 0 && n < 255) early_wrap = 1'b1;
    end
    chk("cycle_steps", n, 255);
    chk("cycle_result", {24'd0, result}, 32'h01);
    chk("cycle_zero_seen", {31'd0, zero_seen}, 32'd0);
    chk("cycle_early_wrap", {31'd0, early_wrap}, 32'd0);
    auto_en = 1'b0;
    tick();
    chk("autoen_drop_running", {31'd0, running}, 32'd0);
    p0 = pulse_cnt;
    ticks(2 * PER);
    chk("autoen_drop_pulses", pulse_cnt - p0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
